// File: rtl/regfile_sb.sv
// Register file with NR combinational read ports, NW write-back ports,
// write-to-read bypass and a per-register scoreboard of pending writes.
module regfile_sb #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int NR     = 2,
    parameter int NW     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NR*ADDR_W-1:0]   rs_addr,
    output logic [NR*WIDTH-1:0]    rs_data,
    output logic [NR-1:0]          rs_ready,
    input  logic                   iss_valid,
    input  logic [ADDR_W-1:0]      iss_rd,
    output logic                   iss_ready,
    input  logic [NW-1:0]          wb_valid,
    input  logic [NW*ADDR_W-1:0]   wb_addr,
    input  logic [NW*WIDTH-1:0]    wb_data,
    output logic [2**ADDR_W-1:0]   busy_vec
);

    localparam int DEPTH = 2**ADDR_W;

    logic [WIDTH-1:0]  regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_set;
    logic [DEPTH-1:0]  busy_clr;

    logic [ADDR_W-1:0] wa [NW];
    logic [WIDTH-1:0]  wd [NW];
    logic [ADDR_W-1:0] ra [NR];
    logic [NW-1:0]     wb_live;
    logic [NW-1:0]     wb_win;
    logic              alloc;

    genvar g;
    generate
        for (g = 0; g < NW; g++) begin : g_wb
            assign wa[g]      = wb_addr[g*ADDR_W +: ADDR_W];
            assign wd[g]      = wb_data[g*WIDTH +: WIDTH];
            assign wb_live[g] = wb_valid[g] && (wa[g] != '0);
        end
        for (g = 0; g < NR; g++) begin : g_rd
            assign ra[g] = rs_addr[g*ADDR_W +: ADDR_W];
        end
    endgenerate

    // A live port wins unless a lower-index live port targets the same register.
    always_comb begin
        wb_win = wb_live;
        for (int j = 1; j < NW; j++) begin
            for (int k = 0; k < j; k++) begin
                if (wb_live[k] && (wa[k] == wa[j])) begin
                    wb_win[j] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (wb_win[j]) begin
                    regs[wa[j]] <= wd[j];
                end
            end
        end
    end

    // A write completing this cycle does not free the slot for a new owner.
    assign iss_ready = (iss_rd == '0) || !busy[iss_rd];
    assign alloc     = iss_valid && iss_ready && (iss_rd != '0);

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (alloc) begin
            busy_set[iss_rd] = 1'b1;
        end
        for (int j = 0; j < NW; j++) begin
            if (wb_live[j]) begin
                busy_clr[wa[j]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~busy_clr) | busy_set;
        end
    end

    assign busy_vec = busy;

    // Walk write ports from highest to lowest so the lowest matching port
    // is the one left driving the bypassed value.
    always_comb begin
        rs_data  = '0;
        rs_ready = '0;
        for (int i = 0; i < NR; i++) begin
            rs_data[i*WIDTH +: WIDTH] = regs[ra[i]];
            rs_ready[i]               = !busy[ra[i]];
            for (int j = NW - 1; j >= 0; j--) begin
                if (wb_live[j] && (wa[j] == ra[i])) begin
                    rs_data[i*WIDTH +: WIDTH] = wd[j];
                    rs_ready[i]               = 1'b1;
                end
            end
            if (ra[i] == '0) begin
                rs_data[i*WIDTH +: WIDTH] = '0;
                rs_ready[i]               = 1'b1;
            end
        end
    end

endmodule
